// File: rtl/game_sprite_pkg.sv
// Shared types and helpers for the sprite mover: motion state, default
// screen/sprite dimensions and the fully-on-screen test.
package game_sprite_pkg;

    typedef enum logic [1:0] {
        FROZEN,
        RUN,
        OUT
    } sprite_state_t;

    localparam int unsigned DEFAULT_SCREEN_WIDTH  = 640;
    localparam int unsigned DEFAULT_SCREEN_HEIGHT = 480;
    localparam int unsigned DEFAULT_SPRITE_WIDTH  = 8;
    localparam int unsigned DEFAULT_SPRITE_HEIGHT = 8;

    // Widened to 32 bits so a coordinate that wrapped below zero reads as a
    // large value and is rejected rather than overflowing back on-screen.
    function automatic logic axis_fits(input int unsigned pos,
                                       input int unsigned extent,
                                       input int unsigned limit);
        return (pos + extent) <= limit;
    endfunction

    function automatic logic within_screen(input int unsigned x,
                                           input int unsigned y,
                                           input int unsigned screen_w,
                                           input int unsigned screen_h,
                                           input int unsigned sprite_w,
                                           input int unsigned sprite_h);
        return axis_fits(x, sprite_w, screen_w) && axis_fits(y, sprite_h, screen_h);
    endfunction

endpackage

// File: rtl/game_sprite_step_timer.sv
// Enable-gated modulo-UPDATE_PERIOD counter; step_due marks the enabled
// cycle on which the sprite should take its next motion step.
module game_sprite_step_timer #(
    parameter int unsigned UPDATE_PERIOD = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic step_due
);

    localparam int CNT_W = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(UPDATE_PERIOD - 1);

    logic [CNT_W-1:0] count;

    assign step_due = enable && (count == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= step_due ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/game_sprite_mover.sv
// One sprite's position/velocity register with paced motion and on-screen
// reporting. Define GAME_SPRITE_MOVER_BOUNCE_EN to reflect off screen edges.
module game_sprite_mover
    import game_sprite_pkg::*;
#(
    parameter int          X_WIDTH       = 10,
    parameter int          Y_WIDTH       = 10,
    parameter int          DXY_WIDTH     = 4,
    parameter int unsigned SCREEN_WIDTH  = DEFAULT_SCREEN_WIDTH,
    parameter int unsigned SCREEN_HEIGHT = DEFAULT_SCREEN_HEIGHT,
    parameter int unsigned SPRITE_WIDTH  = DEFAULT_SPRITE_WIDTH,
    parameter int unsigned SPRITE_HEIGHT = DEFAULT_SPRITE_HEIGHT,
    parameter int unsigned UPDATE_PERIOD = 1_000_000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sprite_write_xy,
    input  logic [X_WIDTH-1:0]          sprite_write_x,
    input  logic [Y_WIDTH-1:0]          sprite_write_y,
    input  logic                        sprite_write_dxy,
    input  logic signed [DXY_WIDTH-1:0] sprite_write_dx,
    input  logic signed [DXY_WIDTH-1:0] sprite_write_dy,
    input  logic                        sprite_enable_update,
    output logic [X_WIDTH-1:0]          sprite_x,
    output logic [Y_WIDTH-1:0]          sprite_y,
    output logic                        sprite_within_screen,
    output logic                        sprite_step
);

    sprite_state_t               state, state_next;
    logic signed [DXY_WIDTH-1:0] dx, dy, dx_next, dy_next;
    logic [X_WIDTH-1:0]          x_next, x_step;
    logic [Y_WIDTH-1:0]          y_next, y_step;
    logic                        step_next;
    logic                        timer_enable, step_due, step_taken;

    assign timer_enable = sprite_enable_update && (state != OUT);
    assign step_taken   = step_due && !sprite_write_xy;

    game_sprite_step_timer #(
        .UPDATE_PERIOD(UPDATE_PERIOD)
    ) u_step_timer (
        .clk     (clk),
        .rst     (rst),
        .enable  (timer_enable),
        .clear   (sprite_write_xy),
        .step_due(step_due)
    );

    // Sign-extended velocity added modulo 2^width, so moving left past zero wraps high.
    assign x_step = sprite_x + X_WIDTH'(dx);
    assign y_step = sprite_y + Y_WIDTH'(dy);

    // OUT is the only state with the sprite off-screen, so the flag follows the state register.
    assign sprite_within_screen = (state != OUT);

    always_comb begin
        x_next     = sprite_x;
        y_next     = sprite_y;
        dx_next    = dx;
        dy_next    = dy;
        state_next = state;
        step_next  = 1'b0;

        if (sprite_write_xy) begin
            x_next     = sprite_write_x;
            y_next     = sprite_write_y;
            state_next = within_screen(32'(sprite_write_x), 32'(sprite_write_y),
                                       SCREEN_WIDTH, SCREEN_HEIGHT,
                                       SPRITE_WIDTH, SPRITE_HEIGHT) ? FROZEN : OUT;
        end else if (state != OUT) begin
            state_next = sprite_enable_update ? RUN : FROZEN;
            if (step_taken) begin
                step_next = 1'b1;
`ifdef GAME_SPRITE_MOVER_BOUNCE_EN
                if (axis_fits(32'(x_step), SPRITE_WIDTH, SCREEN_WIDTH)) begin
                    x_next = x_step;
                end else begin
                    dx_next = -dx;
                end
                if (axis_fits(32'(y_step), SPRITE_HEIGHT, SCREEN_HEIGHT)) begin
                    y_next = y_step;
                end else begin
                    dy_next = -dy;
                end
`else
                x_next = x_step;
                y_next = y_step;
                if (!within_screen(32'(x_step), 32'(y_step),
                                   SCREEN_WIDTH, SCREEN_HEIGHT,
                                   SPRITE_WIDTH, SPRITE_HEIGHT)) begin
                    state_next = OUT;
                end
`endif
            end
        end

        // An explicit velocity load wins over a bounce reversal in the same cycle.
        if (sprite_write_dxy) begin
            dx_next = sprite_write_dx;
            dy_next = sprite_write_dy;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sprite_x    <= '0;
            sprite_y    <= '0;
            dx          <= '0;
            dy          <= '0;
            state       <= FROZEN;
            sprite_step <= 1'b0;
        end else begin
            sprite_x    <= x_next;
            sprite_y    <= y_next;
            dx          <= dx_next;
            dy          <= dy_next;
            state       <= state_next;
            sprite_step <= step_next;
        end
    end

endmodule

// File: tb/tb_game_sprite_mover.sv
// Self-checking bench for game_sprite_mover: directed scenarios plus random
// traffic compared against an arithmetic reference model.
module tb_game_sprite_mover;

    localparam int XW     = 10;
    localparam int YW     = 10;
    localparam int DW     = 4;
    localparam int SW     = 640;
    localparam int SH     = 480;
    localparam int SPW    = 8;
    localparam int SPH    = 8;
    localparam int PERIOD = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 sprite_write_xy;
    logic [XW-1:0]        sprite_write_x;
    logic [YW-1:0]        sprite_write_y;
    logic                 sprite_write_dxy;
    logic signed [DW-1:0] sprite_write_dx;
    logic signed [DW-1:0] sprite_write_dy;
    logic                 sprite_enable_update;
    logic [XW-1:0]        sprite_x;
    logic [YW-1:0]        sprite_y;
    logic                 sprite_within_screen;
    logic                 sprite_step;

    always #5 clk = ~clk;

    game_sprite_mover #(
        .X_WIDTH      (XW),
        .Y_WIDTH      (YW),
        .DXY_WIDTH    (DW),
        .SCREEN_WIDTH (SW),
        .SCREEN_HEIGHT(SH),
        .SPRITE_WIDTH (SPW),
        .SPRITE_HEIGHT(SPH),
        .UPDATE_PERIOD(PERIOD)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .sprite_write_xy     (sprite_write_xy),
        .sprite_write_x      (sprite_write_x),
        .sprite_write_y      (sprite_write_y),
        .sprite_write_dxy    (sprite_write_dxy),
        .sprite_write_dx     (sprite_write_dx),
        .sprite_write_dy     (sprite_write_dy),
        .sprite_enable_update(sprite_enable_update),
        .sprite_x            (sprite_x),
        .sprite_y            (sprite_y),
        .sprite_within_screen(sprite_within_screen),
        .sprite_step         (sprite_step)
    );

    int checks = 0;
    int errors = 0;
    int step_pulses = 0;

    // Reference model: plain integers, enabled-cycle tally and an off-screen flag.
    int mx, my, mdx, mdy, enabled_cycles;
    bit model_out, model_step;

    function automatic bit on_screen(input int x, input int y);
        return (x + SPW <= SW) && (y + SPH <= SH);
    endfunction

    function automatic int wrap(input int v, input int m);
        return ((v % m) + m) % m;
    endfunction

    function automatic int negate_velocity(input int v);
        return (v == -(1 << (DW - 1))) ? v : -v;
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        mx = 0; my = 0; mdx = 0; mdy = 0;
        enabled_cycles = 0;
        model_out = 1'b0;
        model_step = 1'b0;
    endtask

    task automatic model_update(input bit wxy, input int wx, input int wy,
                                input bit wdxy, input int wdx, input int wdy,
                                input bit en);
        int nx, ny;
        bit new_step;
        new_step = 1'b0;
        if (wxy) begin
            mx = wx; my = wy;
            enabled_cycles = 0;
            model_out = !on_screen(wx, wy);
        end else if (!model_out && en) begin
            enabled_cycles++;
            if (enabled_cycles == PERIOD) begin
                enabled_cycles = 0;
                new_step = 1'b1;
                nx = wrap(mx + mdx, 1 << XW);
                ny = wrap(my + mdy, 1 << YW);
`ifdef GAME_SPRITE_MOVER_BOUNCE_EN
                if (nx + SPW <= SW) mx = nx; else mdx = negate_velocity(mdx);
                if (ny + SPH <= SH) my = ny; else mdy = negate_velocity(mdy);
`else
                mx = nx; my = ny;
                if (!on_screen(mx, my)) model_out = 1'b1;
`endif
            end
        end
        model_step = new_step;
        if (wdxy) begin
            mdx = wdx; mdy = wdy;
        end
    endtask

    task automatic applyStimulus(input bit wxy, input int wx, input int wy,
                                 input bit wdxy, input int wdx, input int wdy,
                                 input bit en);
        sprite_write_xy      = wxy;
        sprite_write_x       = XW'(wx);
        sprite_write_y       = YW'(wy);
        sprite_write_dxy     = wdxy;
        sprite_write_dx      = DW'(wdx);
        sprite_write_dy      = DW'(wdy);
        sprite_enable_update = en;
        @(posedge clk);
        model_update(wxy, wx, wy, wdxy, wdx, wdy, en);
        #1;
        checkOutput("x", int'(sprite_x), mx);
        checkOutput("y", int'(sprite_y), my);
        checkOutput("within", int'(sprite_within_screen), int'(!model_out));
        checkOutput("step", int'(sprite_step), int'(model_step));
        if (sprite_step) step_pulses++;
    endtask

    task automatic check_reset_values(input string tag);
        checkOutput({tag, "_x"}, int'(sprite_x), 0);
        checkOutput({tag, "_y"}, int'(sprite_y), 0);
        checkOutput({tag, "_within"}, int'(sprite_within_screen), 1);
        checkOutput({tag, "_step"}, int'(sprite_step), 0);
    endtask

    initial begin
        rst = 1'b0;
        sprite_write_xy = 0; sprite_write_x = '0; sprite_write_y = '0;
        sprite_write_dxy = 0; sprite_write_dx = '0; sprite_write_dy = '0;
        sprite_enable_update = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("por");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Load position and velocity together, then run 12 enabled cycles.
        applyStimulus(1, 100, 50, 1, 2, -1, 0);
        step_pulses = 0;
        for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("run12_pulses", step_pulses, 3);
        checkOutput("run12_x", int'(sprite_x), 106);
        checkOutput("run12_y", int'(sprite_y), 47);

        // Asynchronous reset mid-sequence, away from any clock edge.
        #2;
        rst = 1'b0;
        #1;
        check_reset_values("async");
        @(posedge clk);
        #1;
        check_reset_values("held");
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        check_reset_values("release");
        @(posedge clk);
        #1;

        // Enable bursts: counter holds while enable is low.
        applyStimulus(1, 300, 300, 1, 1, 1, 0);
        step_pulses = 0;
        for (int i = 0; i < 9; i++) applyStimulus(0, 0, 0, 0, 0, 0, (i < 2 || i > 6));
        checkOutput("burst_pulses", step_pulses, 1);
        checkOutput("burst_step_last", int'(sprite_step), 1);
        checkOutput("burst_x", int'(sprite_x), 301);

        // Right edge exit.
        applyStimulus(1, 630, 100, 1, 3, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1);
`ifdef GAME_SPRITE_MOVER_BOUNCE_EN
        checkOutput("edge_x", int'(sprite_x), 630);
        checkOutput("edge_within", int'(sprite_within_screen), 1);
`else
        checkOutput("edge_x", int'(sprite_x), 633);
        checkOutput("edge_within", int'(sprite_within_screen), 0);
`endif
        step_pulses = 0;
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1);
`ifndef GAME_SPRITE_MOVER_BOUNCE_EN
        checkOutput("out_x", int'(sprite_x), 633);
        checkOutput("out_pulses", step_pulses, 0);
`endif
        applyStimulus(1, 10, 10, 0, 0, 0, 0);
        checkOutput("restore_within", int'(sprite_within_screen), 1);

        // Left edge wrap below zero.
        applyStimulus(1, 1, 100, 1, -2, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1);
`ifdef GAME_SPRITE_MOVER_BOUNCE_EN
        checkOutput("wrap_x", int'(sprite_x), 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("bounce_x", int'(sprite_x), 3);
        checkOutput("bounce_within", int'(sprite_within_screen), 1);
`else
        checkOutput("wrap_x", int'(sprite_x), 1023);
        checkOutput("wrap_within", int'(sprite_within_screen), 0);
`endif

        // Position write collides with a due step.
        applyStimulus(1, 50, 50, 1, 1, 1, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 200, 200, 0, 0, 0, 1);
        checkOutput("collide_x", int'(sprite_x), 200);
        checkOutput("collide_y", int'(sprite_y), 200);
        checkOutput("collide_step", int'(sprite_step), 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("collide_no_early", int'(sprite_x), 200);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("collide_next_x", int'(sprite_x), 201);
        checkOutput("collide_next_step", int'(sprite_step), 1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 19) == 0),
                          int'($urandom_range(0, 660)), int'($urandom_range(0, 500)),
                          ($urandom_range(0, 14) == 0),
                          int'($urandom_range(0, 14)) - 7, int'($urandom_range(0, 14)) - 7,
                          ($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
